// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_mdu execute-stage ALU/MDU.
//   alu_op_e     - 5-bit operation code (18..31 are reserved, result 0)
//   alu_state_e  - result FSM states (IDLE / DIV / HOLD)
//   div_spec_t   - divide special-case decode (b==0, signed overflow)
//   div_special  - maps a divide request onto its bypass result
package alu_pkg;

   localparam int ALU_XLEN_DEF = 32;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLT    = 5'd2,
      OP_SLTU   = 5'd3,
      OP_XOR    = 5'd4,
      OP_OR     = 5'd5,
      OP_AND    = 5'd6,
      OP_SLL    = 5'd7,
      OP_SRL    = 5'd8,
      OP_SRA    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_e;

   // hit: bypass the divider. ones: result all ones. pass_a: result = a.
   // hit with neither flag set means result 0.
   typedef struct packed {
      logic hit;
      logic ones;
      logic pass_a;
   } div_spec_t;

   // Signed overflow only occurs with a == MIN, so "DIV -> MIN" is just a.
   function automatic div_spec_t div_special(input logic is_rem,
                                             input logic b_zero,
                                             input logic sovf);
      div_spec_t s;
      s.hit    = b_zero | sovf;
      s.ones   = b_zero & ~is_rem;
      s.pass_a = (b_zero & is_rem) | (sovf & ~is_rem);
      return s;
   endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: unsigned restoring radix-2 divider, one quotient bit per cycle.
// Only built when ALU_MDU_DIV_EN is defined.
//   i_start            - load operands (one-cycle pulse)
//   i_dividend/divisor - unsigned magnitudes
//   o_done             - one-cycle pulse, XLEN cycles after the start edge
//   o_quotient/o_remainder - valid while o_done is high
`ifdef ALU_MDU_DIV_EN
module alu_divider #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic            o_done,
   output logic [XLEN-1:0] o_quotient,
   output logic [XLEN-1:0] o_remainder
);
   localparam int CNT_W = $clog2(XLEN);

   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic [XLEN-1:0]  dvsr;
   logic [XLEN:0]    rem_sh;
   logic [XLEN:0]    diff;

   // The quotient register doubles as the dividend shifter: its MSB feeds
   // the partial remainder while the new quotient bit enters at the LSB.
   assign rem_sh = {o_remainder, o_quotient[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvsr};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt         <= '0;
         busy        <= 1'b0;
         dvsr        <= '0;
         o_done      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else begin
         o_done <= 1'b0;
         if (i_start) begin
            busy        <= 1'b1;
            cnt         <= '0;
            dvsr        <= i_divisor;
            o_quotient  <= i_dividend;
            o_remainder <= '0;
         end else if (busy) begin
            o_quotient  <= {o_quotient[XLEN-2:0], ~diff[XLEN]};
            o_remainder <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            cnt         <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
               busy   <= 1'b0;
               o_done <= 1'b1;
            end
         end
      end
   end
endmodule
`endif

// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU + RV32M multiply/divide with valid/ready
// handshakes on both sides.
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_valid / o_ready      - request handshake (operands, op captured at accept)
//   i_operand_a/b, i_alu_op
//   o_valid / i_ready      - result handshake, o_alu_data held while stalled
// Build option ALU_MDU_DIV_EN: instantiate the iterative divider. Without it
// ops 14..17 return 0 in one cycle and the DIV state is never entered.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN_DEF
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   input  logic [4:0]      i_alu_op,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_alu_data
);
   localparam int SHAMT_W = $clog2(XLEN);

   alu_state_e          state;
   alu_op_e             op;
   logic                accept;
   logic                div_start;
   logic                div_done;
   logic [XLEN-1:0]     div_result;
   logic [XLEN-1:0]     a, b, comb_res;
   logic [SHAMT_W-1:0]  shamt;
   logic                a_sx, b_sx;
   logic [2*XLEN-1:0]   a_ext, b_ext, prod;

   assign op    = alu_op_e'(i_alu_op);
   assign a     = i_operand_a;
   assign b     = i_operand_b;
   assign shamt = b[SHAMT_W-1:0];

   // One 2*XLEN multiplier serves all four ops; the extension choice decides
   // signed/unsigned interpretation of each operand.
   assign a_sx  = ((op == OP_MULH) || (op == OP_MULHSU)) && a[XLEN-1];
   assign b_sx  = (op == OP_MULH) && b[XLEN-1];
   assign a_ext = {{XLEN{a_sx}}, a};
   assign b_ext = {{XLEN{b_sx}}, b};
   assign prod  = a_ext * b_ext;

   // Combinational from i_ready so a stalled result and a new request can
   // swap in the same cycle.
   assign o_ready = (state == ST_IDLE) || ((state == ST_HOLD) && i_ready);
   assign o_valid = (state == ST_HOLD);
   assign accept  = i_valid && o_ready;

`ifdef ALU_MDU_DIV_EN
   logic            div_signed, div_is_rem, div_sovf, div_norm;
   div_spec_t       div_sp;
   logic [XLEN-1:0] div_res_spec, a_mag, b_mag, quot, rem;
   logic            neg_q, neg_r, rem_sel;

   assign div_signed   = (op == OP_DIV) || (op == OP_REM);
   assign div_is_rem   = (op == OP_REM) || (op == OP_REMU);
   assign div_sovf     = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
   assign div_sp       = div_special(div_is_rem, b == '0, div_sovf);
   assign div_res_spec = div_sp.ones ? '1 : (div_sp.pass_a ? a : '0);
   assign div_norm     = (op >= OP_DIV) && (op <= OP_REMU) && !div_sp.hit;
   assign div_start    = accept && div_norm;
   assign a_mag        = (div_signed && a[XLEN-1]) ? -a : a;
   assign b_mag        = (div_signed && b[XLEN-1]) ? -b : b;

   alu_divider #(.XLEN(XLEN)) u_div (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (div_start),
      .i_dividend  (a_mag),
      .i_divisor   (b_mag),
      .o_done      (div_done),
      .o_quotient  (quot),
      .o_remainder (rem)
   );

   // Sign fix-up: quotient negative when signs differ, remainder follows a.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         rem_sel <= 1'b0;
      end else if (div_start) begin
         neg_q   <= div_signed && (a[XLEN-1] ^ b[XLEN-1]);
         neg_r   <= div_signed && a[XLEN-1];
         rem_sel <= div_is_rem;
      end
   end

   assign div_result = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);
`else
   assign div_start  = 1'b0;
   assign div_done   = 1'b0;
   assign div_result = '0;
`endif

   always_comb begin
      comb_res = '0;
      case (op)
         OP_ADD:    comb_res = a + b;
         OP_SUB:    comb_res = a - b;
         OP_SLT:    comb_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:   comb_res = {{(XLEN-1){1'b0}}, a < b};
         OP_XOR:    comb_res = a ^ b;
         OP_OR:     comb_res = a | b;
         OP_AND:    comb_res = a & b;
         OP_SLL:    comb_res = a << shamt;
         OP_SRL:    comb_res = a >> shamt;
         OP_SRA:    comb_res = $unsigned($signed(a) >>> shamt);
         OP_MUL:    comb_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:
                    comb_res = prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                    comb_res = div_res_spec;
`endif
         default:   comb_res = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         o_alu_data <= '0;
      end else if (accept) begin
         if (div_start) begin
            state <= ST_DIV;
         end else begin
            state      <= ST_HOLD;
            o_alu_data <= comb_res;
         end
      end else if ((state == ST_HOLD) && i_ready) begin
         state <= ST_IDLE;
      end else if ((state == ST_DIV) && div_done) begin
         state      <= ST_HOLD;
         o_alu_data <= div_result;
      end
   end
endmodule
